// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter: round-robin arbiter that serialises requester commands onto one APB master
// and returns a one-cycle response with read data to the issuing requester.
module apb_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int DATA    = 32,
    parameter int ADDR    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DATA-1:0]    rsp_rdata,
    output logic               busy,
    output logic               hang,
    output logic               transfer,
    output logic               rw,
    output logic [ADDR-1:0]    addr_in,
    output logic [DATA-1:0]    data_in,
    input  logic               psel,
    input  logic               penable,
    input  logic               pready,
    input  logic [DATA-1:0]    prdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d, owner_q, owner_d, grant;
    logic            found, rw_q, rw_d, hang_q, hang_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [DATA-1:0] data_q, data_d, rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // search starts just after the last served requester, so it has lowest priority
    always_comb begin
        grant = last_q;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
                found = 1'b1;
                grant = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        hang_d    = hang_q;
        req_ready = '0;
        case (state_q)
            IDLE: if (found) begin
                req_ready[grant] = presetn;
                state_d = ISSUE;
                last_d  = grant;
                owner_d = grant;
                rw_d    = req_write[grant];
                addr_d  = req_addr[grant*ADDR +: ADDR];
                data_d  = req_wdata[grant*DATA +: DATA];
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (psel && penable && pready) begin
                state_d = RESP;
                rdata_d = rw_q ? '0 : prdata;
            end else if (psel && penable && cnt_q != CW'(TIMEOUT)) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(TIMEOUT)) hang_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            hang_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            hang_q  <= hang_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
    assign rsp_rdata = rdata_q;
    assign busy      = state_q != IDLE;
    assign hang      = hang_q;
    assign transfer  = state_q == ISSUE;
    assign rw        = rw_q;
    assign addr_in   = addr_q;
    assign data_in   = data_q;
endmodule

// File: doc/apb_cmd_arbiter.md
# apb_cmd_arbiter

Round-robin command arbiter and sequencer that shares one APB master between NREQ requesters. Each requester presents a read/write command on a valid/ready handshake. The block serialises the commands into the master's `transfer`/`rw`/`addr_in`/`data_in` inputs and holds them stable for the whole transfer. It monitors the APB bus for completion and returns a one-cycle response, with read data, to the requester that issued the command.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `DATA`, 32: APB data width.
- `ADDR`, 32: APB address width.
- `TIMEOUT`, 255: ACCESS-phase wait cycles before `hang` sets; minimum 1.
- `pclk` in 1: APB clock; the only clock.
- `presetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester command valid.
- `req_ready` out NREQ: per-requester command accepted. At most one bit is high.
- `req_write` in NREQ: per-requester direction; 1 = write, 0 = read.
- `req_addr` in NREQ*ADDR: flattened addresses; requester i occupies `[i*ADDR +: ADDR]`.
- `req_wdata` in NREQ*DATA: flattened write data; requester i occupies `[i*DATA +: DATA]`.
- `rsp_valid` out NREQ: one-cycle completion pulse to the issuing requester.
- `rsp_rdata` out DATA: `prdata` captured at completion for reads; 0 for writes. Valid with `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `hang` out 1: sticky flag, cleared only by reset.
- `transfer` out 1: to the master; start pulse.
- `rw` out 1: to the master; 1 = write.
- `addr_in` out ADDR: to the master.
- `data_in` out DATA: to the master.
- `psel` in 1: bus monitor.
- `penable` in 1: bus monitor.
- `pready` in 1: bus monitor.
- `prdata` in DATA: bus monitor.

## Operation
- **States.**
  - IDLE: no transfer owned.
  - ISSUE: command latched, `transfer`=1.
  - WAIT: master in SETUP/ACCESS.
  - RESP: `rsp_valid` pulse.
- **IDLE.**
  - The grant is computed combinationally: the first requester with `req_valid`=1 searching from `last+1` modulo NREQ.
  - `req_ready[g]`=1 for that requester only.
  - On `req_valid[g] & req_ready[g]` at a rising edge:
    - latch `rw`, `addr_in` and `data_in` from requester g, and latch owner=g;
    - set `last`=g;
    - go to ISSUE.
  - With no valid requester, stay in IDLE with `req_ready`=0.
- **ISSUE.** `transfer`=1 for exactly one cycle, then WAIT. `transfer` is 0 in every other state.
- **WAIT.**
  - Completion is `psel & penable & pready`. On completion: capture `prdata` (reads) or 0 (writes) into `rsp_rdata`, then go to RESP.
  - Otherwise stay in WAIT.
  - Wait counter: cleared on entry to WAIT, incremented each cycle that `psel & penable & !pready`, and saturating. When it reaches TIMEOUT, `hang`:=1. The arbiter keeps waiting; it never aborts a transfer.
- **RESP.** `rsp_valid[owner]`=1 for one cycle, then IDLE.
- **Stability.**
  - `rw`, `addr_in` and `data_in` are registered. They do not change from ISSUE through RESP.
  - They keep their last value in IDLE until the next accept.
- **Fairness.** The requester just served has lowest priority in the next arbitration. With all requesters valid, grant order is 0,1,…,NREQ-1,0.
- **Reset.**
  - `last`=NREQ-1, so requester 0 wins first.
  - State IDLE.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `busy`, `hang`, `transfer`, `rw`, `addr_in`, `data_in`.
- **Reset mid-operation.** Any in-flight command is dropped with no `rsp_valid`. Requesters re-present after reset.
- **Boundaries.**
  - `req_valid` withdrawn before acceptance has no effect.
  - A requester may assert `req_valid` for its next command during RESP. It is arbitrated in the following IDLE cycle.

## Timing
- **Per-transfer sequence with zero-wait slave.**
  - Accept edge at the end of IDLE cycle T.
  - ISSUE at T+1: master samples `transfer`.
  - Master SETUP at T+2, ACCESS at T+3; completion seen in T+3.
  - RESP at T+4: `rsp_valid` high.
  - IDLE at T+5.
- **Latency.** Accept to `rsp_valid` is 4 cycles plus N slave wait states.
- **Throughput.** Back-to-back commands from different requesters issue one every 5 cycles.
- **`busy`.** High from T+1 through T+4.

## Test plan
- **Single write.** Requester 0 writes addr 0x10, data 0xDEADBEEF; slave `pready`=1.
  - `transfer` pulses at T+1.
  - `addr_in`=0x10 and `rw`=1, stable T+1..T+4.
  - `rsp_valid[0]` at T+4 with `rsp_rdata`=0.
- **Read with 3 wait states.** Requester 1 reads addr 0x20; slave returns 0x1234_5678.
  - `rsp_valid[1]` at T+7 with `rsp_rdata`=0x12345678.
  - `hang` stays 0.
- **Round-robin.** NREQ=2, both requesters continuously valid.
  - Grant sequence 0,1,0,1.
  - `req_ready` is never high in both bits.
  - Each `rsp_valid` goes to the correct requester.
- **Simultaneous request after service.** Requester 0 served, then requester 0 re-requests in RESP while requester 1 is also valid → requester 1 is granted next.
- **Timeout.** TIMEOUT=4, slave holds `pready`=0 for 10 cycles.
  - `hang` rises after the 4th wait cycle.
  - The transfer still completes, with `rsp_valid` on the eventual `pready`.
  - `hang` stays 1 until reset.
- **Reset mid-transfer.** `presetn` is driven low during WAIT.
  - All outputs go to 0 asynchronously.
  - No `rsp_valid` is issued.
  - After release, requester 0 wins first.
